// File: rtl/div_flotante_if.sv
// Operand/result handshake bundle for the 13-bit float divider.
// The master side supplies operands and accepts quotients; the divider is the slave side.
interface div_flotante_if #(
    parameter int NB_FLOAT = 13
);
    logic [NB_FLOAT-1:0] i_flotante_1;
    logic [NB_FLOAT-1:0] i_flotante_2;
    logic                i_valid;
    logic                o_ready;
    logic [NB_FLOAT-1:0] o_flotante;
    logic                o_valid;
    logic                i_ready;
    logic                o_ovf;
    logic                o_unf;
    logic                o_div_zero;

    modport master (
        output i_flotante_1, i_flotante_2, i_valid, i_ready,
        input  o_ready, o_flotante, o_valid, o_ovf, o_unf, o_div_zero
    );

    modport slave (
        input  i_flotante_1, i_flotante_2, i_valid, i_ready,
        output o_ready, o_flotante, o_valid, o_ovf, o_unf, o_div_zero
    );
endinterface

// File: rtl/div_flotante.sv
// Iterative 13-bit float divider: restoring division, one quotient bit per clock.
// Fixed latency for every operand pair, truncating rounding, saturating on overflow.
module div_flotante #(
    parameter int NB_FLOAT = 13,
    parameter int NB_EXP   = 4,
    parameter int NB_MANT  = 8,
    parameter int BIAS     = 7
) (
    input logic            clock,
    input logic            i_rst_n,
    div_flotante_if.slave  bus
);
    localparam int NB_SIG = NB_MANT + 1;
    localparam int NB_Q   = NB_MANT + 2;
    localparam int NB_E   = NB_EXP + 3;
    localparam int NB_CNT = $clog2(NB_Q + 1);

    localparam logic signed [NB_E-1:0] BIAS_E  = NB_E'(BIAS);
    localparam logic signed [NB_E-1:0] EXP_MAX = NB_E'((1 << NB_EXP) - 1);
    localparam logic signed [NB_E-1:0] EXP_MIN = NB_E'(1);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t              state;
    logic [NB_EXP-1:0]   exp_1;
    logic [NB_EXP-1:0]   exp_2;
    logic                zero_1;
    logic                zero_2;
    logic                sign;
    logic [NB_SIG-1:0]   divisor;
    logic [NB_SIG:0]     rem;
    logic [NB_Q-1:0]     quo;
    logic [NB_CNT-1:0]   count;
    logic [NB_FLOAT-1:0] result;
    logic                ovf;
    logic                unf;
    logic                div_zero;
    logic                valid;
    logic                ready;

    logic                    rem_ge;
    logic [NB_SIG:0]         rem_next;
    logic signed [NB_E-1:0]  exp_adj;
    logic signed [NB_E-1:0]  exp_res;
    logic [NB_MANT-1:0]      mant_res;
    logic [NB_FLOAT-1:0]     pack_val;
    logic                    pack_ovf;
    logic                    pack_unf;
    logic                    pack_dz;

    // Compare-then-shift keeps the first step's bit as the integer bit of the quotient.
    always_comb begin
        rem_ge   = (rem >= {1'b0, divisor});
        rem_next = rem_ge ? ((rem - {1'b0, divisor}) << 1) : (rem << 1);
    end

    always_comb begin
        pack_val = '0;
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_dz  = 1'b0;
        exp_adj  = quo[NB_Q-1] ? BIAS_E : (BIAS_E - NB_E'(1));
        exp_res  = $signed({{(NB_E-NB_EXP){1'b0}}, exp_1})
                 - $signed({{(NB_E-NB_EXP){1'b0}}, exp_2})
                 + exp_adj;
        mant_res = quo[NB_Q-1] ? quo[NB_Q-2:1] : quo[NB_MANT-1:0];
        if (zero_2) begin
            pack_val = {sign, {(NB_FLOAT-1){1'b1}}};
            pack_dz  = 1'b1;
        end else if (zero_1) begin
            pack_val = '0;
        end else if (exp_res > EXP_MAX) begin
            pack_val = {sign, {(NB_FLOAT-1){1'b1}}};
            pack_ovf = 1'b1;
        end else if (exp_res < EXP_MIN) begin
            pack_val = '0;
            pack_unf = 1'b1;
        end else begin
            pack_val = {sign, exp_res[NB_EXP-1:0], mant_res};
        end
    end

    always_ff @(posedge clock) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            valid    <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            div_zero <= 1'b0;
            exp_1    <= '0;
            exp_2    <= '0;
            zero_1   <= 1'b0;
            zero_2   <= 1'b0;
            sign     <= 1'b0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid && ready) begin
                        sign    <= bus.i_flotante_1[NB_FLOAT-1] ^ bus.i_flotante_2[NB_FLOAT-1];
                        exp_1   <= bus.i_flotante_1[NB_FLOAT-2 -: NB_EXP];
                        exp_2   <= bus.i_flotante_2[NB_FLOAT-2 -: NB_EXP];
                        zero_1  <= (bus.i_flotante_1[NB_FLOAT-2 -: NB_EXP] == '0);
                        zero_2  <= (bus.i_flotante_2[NB_FLOAT-2 -: NB_EXP] == '0);
                        rem     <= {2'b01, bus.i_flotante_1[NB_MANT-1:0]};
                        divisor <= {1'b1, bus.i_flotante_2[NB_MANT-1:0]};
                        quo     <= '0;
                        count   <= NB_CNT'(NB_Q);
                        ready   <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= {quo[NB_Q-2:0], rem_ge};
                    count <= count - NB_CNT'(1);
                    if (count == NB_CNT'(1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result   <= pack_val;
                    ovf      <= pack_ovf;
                    unf      <= pack_unf;
                    div_zero <= pack_dz;
                    valid    <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid    <= 1'b0;
                        ready    <= 1'b1;
                        ovf      <= 1'b0;
                        unf      <= 1'b0;
                        div_zero <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid;
    assign bus.o_flotante = result;
    assign bus.o_ovf      = ovf;
    assign bus.o_unf      = unf;
    assign bus.o_div_zero = div_zero;
endmodule

// File: tb/tb_div_flotante.sv
// Directed bench for the 13-bit float divider; expected quotients are hand-computed.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_div_flotante;
    localparam logic [12:0] A_35    = 13'b0_1100_00011101;
    localparam logic [12:0] A_35N   = 13'b1_1100_00011101;
    localparam logic [12:0] B_NEG   = 13'b1_0101_11000110;
    localparam logic [12:0] Q_ACC   = 13'b1_1101_01000001;
    localparam logic [12:0] ONE     = 13'b0_0111_00000000;
    localparam logic [12:0] NEG18   = 13'b1_1011_00101011;
    localparam logic [12:0] THREE   = 13'b0_1000_10000000;
    localparam logic [12:0] TWO     = 13'b0_1000_00000000;
    localparam logic [12:0] TWO_N   = 13'b1_1000_00000000;
    localparam logic [12:0] Q_1P5   = 13'b0_0111_10000000;
    localparam logic [12:0] Q_1P5N  = 13'b1_0111_10000000;
    localparam logic [12:0] SAT_POS = 13'b0_1111_11111111;
    localparam logic [12:0] SAT_NEG = 13'b1_1111_11111111;
    localparam logic [12:0] MAXN    = 13'b0_1111_00000000;
    localparam logic [12:0] MINN    = 13'b0_0001_00000000;

    logic clock;
    logic rst_n;
    int   checks;
    int   failures;

    div_flotante_if bus ();

    div_flotante dut (
        .clock   (clock),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one division from a falling edge; returns outputs seen on the first valid cycle.
    task automatic run_op(input logic [12:0] a, input logic [12:0] b,
                          output logic [12:0] res, output logic ovf, output logic unf,
                          output logic dz, output int lat, output bit tout);
        int n;
        n    = 0;
        tout = 1'b0;
        lat  = 0;
        while (!bus.o_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        bus.i_flotante_1 = a;
        bus.i_flotante_2 = b;
        bus.i_valid      = 1'b1;
        bus.i_ready      = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.i_valid      = 1'b0;
        bus.i_flotante_1 = 13'h1abc;
        bus.i_flotante_2 = 13'h0123;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!bus.o_valid && lat < 30);
        if (!bus.o_valid) tout = 1'b1;
        res = bus.o_flotante;
        ovf = bus.o_ovf;
        unf = bus.o_unf;
        dz  = bus.o_div_zero;
        bus.i_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 1", bus.o_ready);
        end
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_valid);
        end
        checks++;
        if (bus.o_flotante !== 13'd0) begin
            failures++;
            $display("[TB] FAIL reset_result: got %b expected 0", bus.o_flotante);
        end
        checks++;
        if ({bus.o_ovf, bus.o_unf, bus.o_div_zero} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 000",
                     {bus.o_ovf, bus.o_unf, bus.o_div_zero});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_accuracy();
        logic [12:0] res;
        logic ovf, unf, dz;
        int lat;
        bit tout;
        run_op(A_35, B_NEG, res, ovf, unf, dz, lat, tout);
        checks++;
        if (tout !== 1'b0 || res !== Q_ACC) begin
            failures++;
            $display("[TB] FAIL accuracy_result: got %b timeout=%0d expected %b", res, tout, Q_ACC);
        end
        checks++;
        if ({ovf, unf, dz} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL accuracy_flags: got %b expected 000", {ovf, unf, dz});
        end
        checks++;
        if (lat !== 11) begin
            failures++;
            $display("[TB] FAIL accuracy_latency: got %0d expected 11", lat);
        end
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accuracy_release: got valid=%b ready=%b expected valid=0 ready=1",
                     bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_identity();
        logic [12:0] ops_a [4];
        logic [12:0] ops_b [4];
        logic [12:0] exp_q [4];
        logic [12:0] res;
        logic ovf, unf, dz;
        int lat;
        bit tout;
        ops_a = '{ONE, NEG18, THREE, THREE};
        ops_b = '{ONE, NEG18, TWO, TWO_N};
        exp_q = '{ONE, ONE, Q_1P5, Q_1P5N};
        for (int i = 0; i < 4; i++) begin
            run_op(ops_a[i], ops_b[i], res, ovf, unf, dz, lat, tout);
            checks++;
            if (tout !== 1'b0 || res !== exp_q[i] || {ovf, unf, dz} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL identity_%0d: got %b flags=%b timeout=%0d expected %b flags=000",
                         i, res, {ovf, unf, dz}, tout, exp_q[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [12:0] ops_a [3];
        logic [12:0] exp_q [3];
        logic [12:0] res;
        logic ovf, unf, dz;
        int lat;
        bit tout;
        ops_a = '{A_35, 13'd0, A_35N};
        exp_q = '{SAT_POS, SAT_POS, SAT_NEG};
        for (int i = 0; i < 3; i++) begin
            run_op(ops_a[i], 13'd0, res, ovf, unf, dz, lat, tout);
            checks++;
            if (tout !== 1'b0 || res !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL div_zero_result_%0d: got %b expected %b", i, res, exp_q[i]);
            end
            checks++;
            if ({ovf, unf, dz} !== 3'b001 || lat !== 11) begin
                failures++;
                $display("[TB] FAIL div_zero_flags_%0d: got flags=%b latency=%0d expected flags=001 latency=11",
                         i, {ovf, unf, dz}, lat);
            end
        end
    endtask

    task automatic test_range();
        logic [12:0] ops_a [3];
        logic [12:0] ops_b [3];
        logic [12:0] exp_q [3];
        logic [2:0]  exp_f [3];
        logic [12:0] res;
        logic ovf, unf, dz;
        int lat;
        bit tout;
        ops_a = '{MAXN, MINN, 13'd0};
        ops_b = '{MINN, MAXN, A_35};
        exp_q = '{SAT_POS, 13'd0, 13'd0};
        exp_f = '{3'b100, 3'b010, 3'b000};
        for (int i = 0; i < 3; i++) begin
            run_op(ops_a[i], ops_b[i], res, ovf, unf, dz, lat, tout);
            checks++;
            if (tout !== 1'b0 || res !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL range_result_%0d: got %b expected %b", i, res, exp_q[i]);
            end
            checks++;
            if ({ovf, unf, dz} !== exp_f[i] || lat !== 11) begin
                failures++;
                $display("[TB] FAIL range_flags_%0d: got flags=%b latency=%0d expected flags=%b latency=11",
                         i, {ovf, unf, dz}, lat, exp_f[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int n;
        bus.i_flotante_1 = A_35;
        bus.i_flotante_2 = B_NEG;
        bus.i_valid      = 1'b1;
        bus.i_ready      = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.i_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.i_flotante_1 = ONE;
        bus.i_flotante_2 = ONE;
        bus.i_valid      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.o_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL busy_ready_%0d: got %b expected 0", i, bus.o_ready);
            end
            @(posedge clock);
            @(negedge clock);
        end
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 30) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_flotante !== Q_ACC) begin
            failures++;
            $display("[TB] FAIL hold_first: got valid=%b result=%b expected valid=1 result=%b",
                     bus.o_valid, bus.o_flotante, Q_ACC);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_flotante !== Q_ACC || bus.o_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_cycle_%0d: got valid=%b result=%b ready=%b expected 1 %b 0",
                         i, bus.o_valid, bus.o_flotante, bus.o_ready, Q_ACC);
            end
        end
        bus.i_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release: got valid=%b ready=%b expected valid=0 ready=1",
                     bus.o_valid, bus.o_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL no_queue_%0d: got valid=%b ready=%b expected valid=0 ready=1",
                         i, bus.o_valid, bus.o_ready);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [12:0] res;
        logic ovf, unf, dz;
        int lat;
        bit tout;
        bus.i_flotante_1 = THREE;
        bus.i_flotante_2 = TWO;
        bus.i_valid      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.i_valid = 1'b0;
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        rst_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_flotante !== 13'd0) begin
            failures++;
            $display("[TB] FAIL midop_reset: got ready=%b valid=%b result=%b expected 1 0 0",
                     bus.o_ready, bus.o_valid, bus.o_flotante);
        end
        repeat (12) begin
            @(posedge clock);
            @(negedge clock);
        end
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_discard: got valid=%b expected 0", bus.o_valid);
        end
        run_op(ONE, ONE, res, ovf, unf, dz, lat, tout);
        checks++;
        if (tout !== 1'b0 || res !== ONE || lat !== 11) begin
            failures++;
            $display("[TB] FAIL midop_recover: got %b latency=%0d expected %b latency=11", res, lat, ONE);
        end
    endtask

    task automatic test_back_to_back();
        int edge_n;
        int valid_edge;
        int accept2;
        int valid2;
        bit saw_ready;
        logic [12:0] r1;
        logic [12:0] r2;
        edge_n     = 0;
        valid_edge = -1;
        accept2    = -1;
        valid2     = -1;
        saw_ready  = 1'b0;
        r1         = '0;
        r2         = '0;
        bus.i_flotante_1 = THREE;
        bus.i_flotante_2 = TWO;
        bus.i_valid      = 1'b1;
        bus.i_ready      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.i_flotante_1 = A_35;
        bus.i_flotante_2 = B_NEG;
        while (edge_n < 40 && valid2 < 0) begin
            @(posedge clock);
            edge_n++;
            @(negedge clock);
            if (accept2 < 0) begin
                if (bus.o_valid && valid_edge < 0) begin
                    valid_edge = edge_n;
                    r1 = bus.o_flotante;
                end
                if (bus.o_ready) begin
                    saw_ready = 1'b1;
                end else if (saw_ready) begin
                    accept2 = edge_n;
                    bus.i_valid = 1'b0;
                end
            end else if (bus.o_valid) begin
                valid2 = edge_n;
                r2 = bus.o_flotante;
            end
        end
        bus.i_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.i_ready = 1'b0;
        checks++;
        if (valid_edge !== 11 || r1 !== Q_1P5) begin
            failures++;
            $display("[TB] FAIL b2b_first: got edge=%0d result=%b expected edge=11 result=%b",
                     valid_edge, r1, Q_1P5);
        end
        checks++;
        if (accept2 !== 13) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got %0d expected 13", accept2);
        end
        checks++;
        if (valid2 !== 24 || r2 !== Q_ACC) begin
            failures++;
            $display("[TB] FAIL b2b_second: got edge=%0d result=%b expected edge=24 result=%b",
                     valid2, r2, Q_ACC);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b1;
        bus.i_flotante_1 = '0;
        bus.i_flotante_2 = '0;
        bus.i_valid      = 1'b0;
        bus.i_ready      = 1'b0;
        @(negedge clock);
        test_reset();
        test_accuracy();
        test_identity();
        test_div_zero();
        test_range();
        test_handshake();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_flotante.md
Name: div_flotante

Overview:
- Iterative 13-bit floating-point divider: quotient = i_flotante_1 / i_flotante_2.
- Inverse companion of the team's 13-bit float multiplier; uses the same number format.
- Restoring division produces one significand bit per clock.
- Valid/ready handshake on both input and output; sits in the float datapath next to the multiplier.

Parameters:
- NB_FLOAT, 13, total word width (sign + exponent + mantissa).
- NB_EXP, 4, exponent field width.
- NB_MANT, 8, stored mantissa width (hidden leading 1 not stored).
- BIAS, 7, exponent bias.

Ports:
- clock  in  1  system clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_flotante_1  in  13  dividend {sign, exp[3:0], mant[7:0]}.
- i_flotante_2  in  13  divisor, same format.
- i_valid  in  1  operands valid.
- o_ready  out  1  divider idle, can accept operands.
- o_flotante  out  13  quotient.
- o_valid  out  1  quotient valid.
- i_ready  in  1  downstream accepts quotient.
- o_ovf  out  1  overflow flag; result saturated.
- o_unf  out  1  underflow flag; result flushed to zero.
- o_div_zero  out  1  divisor was zero.

Behaviour:
- Format: value = (-1)^s * 1.mant * 2^(exp-BIAS). Exp field 0 means zero, whatever the mantissa. No denormals, no inf/NaN. Exp 15 is a normal exponent.
- Reset (i_rst_n=0 at a rising edge): state=IDLE, o_ready=1, o_valid=0, o_flotante=0, all flags=0. Reset mid-operation aborts; the pending result is discarded.
- FSM states: IDLE, CALC, NORM, DONE.
  - IDLE: o_ready=1. On i_valid && o_ready at edge E0: register both operands, sign = s1^s2, load counter = NB_MANT+2, go to CALC.
  - CALC: o_ready=0. One restoring step per edge on 9-bit significands {1,mant}. Shift the partial remainder left by 1; if remainder >= divisor, subtract and shift in quotient bit 1, else shift in 0. Run NB_MANT+2 = 10 iterations (E1..E10) for a 10-bit quotient q[9:0] with q[9] as the integer bit. Decrement the counter each step; go to NORM when it reaches 0.
  - NORM: one edge (E11). Normalise, pack the result and flags into output registers, go to DONE.
    - If q[9]=1: mant = q[8:1], e = e1 - e2 + BIAS.
    - Else: mant = q[7:0], e = e1 - e2 + BIAS - 1.
    - Compute e as a signed 7-bit value.
  - DONE: o_valid=1; o_flotante and flags are held stable. On i_ready=1 at an edge: o_valid←0 and go to IDLE. o_ready rises one edge after the output handshake, so back-to-back throughput is one operation per NB_MANT+5 clocks minimum.
- Latency: o_valid is high after exactly NB_MANT+3 = 11 rising edges counted from the accept edge. Latency is fixed for all operand values, special cases included.
- Rounding: truncation (the remainder is discarded).
- Special cases, applied in NORM with priority top-down:
  1. Divisor zero: o_flotante={sign,1111,11111111}, o_div_zero=1. This includes 0/0.
  2. Dividend zero: o_flotante=13'd0 (sign forced 0), all flags 0.
  3. e > 15: o_flotante={sign,1111,11111111}, o_ovf=1.
  4. e < 1: o_flotante=13'd0, o_unf=1.
- Flags are valid only while o_valid=1. They are cleared on leaving DONE.
- i_valid asserted while o_ready=0 is ignored and does not queue. Input operands may change freely after the accept edge.
- i_ready asserted outside DONE has no effect.

Test Plan:
- Accuracy: 35.625 (0_1100_00011101) / -0.443359375 (1_0101_11000110) → 1_1101_01000001 (-80.25, truncated from -80.35). Flags 0. o_valid exactly 11 edges after accept.
- Identity and commutation of sign: 1.0/1.0 (0_0111_00000000 both) → 0_0111_00000000. Then -18.6875 (1_1011_00101011) / -18.6875 → 0_0111_00000000.
- Division by zero: 0_1100_00011101 / 13'd0 → 0_1111_11111111, o_div_zero=1. Then 13'd0 / 13'd0 → same saturated value, o_div_zero=1.
- Range limits:
  - 0_1111_00000000 / 0_0001_00000000 → 0_1111_11111111, o_ovf=1.
  - 0_0001_00000000 / 0_1111_00000000 → 13'd0, o_unf=1.
  - 0 / 35.625 → 13'd0, flags 0.
- Handshake: hold i_ready=0 for 20 cycles in DONE → o_valid and o_flotante held constant, o_ready=0. Pulse i_valid during CALC → ignored. Release i_ready → o_valid falls and o_ready rises on the following edge.
- Reset mid-op: assert i_rst_n=0 for 1 edge at E5 of a division → next edge state IDLE, o_ready=1, o_valid=0, o_flotante=0. A subsequent 1.0/1.0 completes normally in 11 edges.
